// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Optional signed mode is enabled by defining MUL_SEQ_SIGNED_EN.
package mul_seq_pkg;

    localparam int MUL_SEQ_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        NEG  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_seq_adder.sv
// Ripple-free behavioural adder used as the multiplier's partial-product datapath.
module mul_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    assign {COUT, SUM} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands (adds one NEG cycle).
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_SEQ_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH:0]     partial;
`ifdef MUL_SEQ_SIGNED_EN
    logic               sign;
`endif

    mul_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .A    (acc[2*WIDTH-1:WIDTH]),
        .B    (mcand),
        .CIN  (1'b0),
        .SUM  (sum),
        .COUT (cout)
    );

    // Carry-out becomes the new top bit so no partial product bit is lost.
    assign partial = mplier[0] ? {cout, sum} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            sign        <= 1'b0;
`endif
        end else if (flush) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
`ifdef MUL_SEQ_SIGNED_EN
                        mcand  <= a[WIDTH-1] ? -a : a;
                        mplier <= b[WIDTH-1] ? -b : b;
                        sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`else
                        mcand  <= a;
                        mplier <= b;
`endif
                        acc         <= '0;
                        count       <= '0;
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    acc    <= {partial, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
`ifdef MUL_SEQ_SIGNED_EN
                        state     <= NEG;
`else
                        state     <= DONE;
                        res_valid <= 1'b1;
`endif
                    end
                end
`ifdef MUL_SEQ_SIGNED_EN
                NEG: begin
                    if (sign) acc <= -acc;
                    state     <= DONE;
                    res_valid <= 1'b1;
                end
`endif
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed, table-driven bench for mul_seq (honours MUL_SEQ_SIGNED_EN).
module tb_mul_seq;

`ifdef MUL_SEQ_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] product;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    mul_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("launch_ready", {63'd0, start_ready}, 64'd1);
        start_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Counts cycles from the accepting edge to res_valid; bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic wait_result(input string name, input logic [63:0] exp);
        int cyc;
        wait_valid(cyc);
        check({name, "_latency"}, 64'(cyc), 64'(LAT));
        check({name, "_product"}, product, exp);
        @(posedge clk);
        #1;
        check({name, "_idle"}, {62'd0, busy, res_valid}, 64'd0);
    endtask

    initial begin
        int cyc;
        int seen;

`ifdef MUL_SEQ_SIGNED_EN
        vecs[0] = '{32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'd4};
        vecs[2] = '{32'd3,         32'd5,         64'h0F};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
        vecs[4] = '{32'h8000_0000, 32'd2,         64'hFFFF_FFFF_0000_0000};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[7] = '{32'd0,         32'hFFFF_FFFF, 64'd0};
`else
        vecs[0] = '{32'd3,         32'd5,         64'h0F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,         32'hFFFF_FFFF, 64'd0};
        vecs[3] = '{32'd7,         32'd6,         64'h2A};
        vecs[4] = '{32'h8000_0000, 32'd2,         64'h1_0000_0000};
        vecs[5] = '{32'h1234_5678, 32'h10,        64'h1_2345_6780};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF};
        vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000};
`endif

        rst_n       = 1'b0;
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        flush       = 1'b0;
        res_ready   = 1'b1;
        #12;
        check("reset_outputs", {start_ready, res_valid, busy, product[60:0]}, {1'b1, 63'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-pressure in DONE: output held, start requests ignored.
        res_ready = 1'b0;
        launch(32'd3, 32'd5);
        wait_valid(cyc);
        check("bp_latency", 64'(cyc), 64'(LAT));
        start_valid = 1'b1;
        a = 32'd9;
        b = 32'd9;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {res_valid, start_ready, product[61:0]}, {1'b1, 1'b0, 62'h0F});
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {61'd0, start_ready, res_valid, busy}, 64'b100);
        start_valid = 1'b0;

        // Flush overrides a coincident start in IDLE.
        @(negedge clk);
        start_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush = 1'b0;
        check("flush_vs_start", {62'd0, busy, start_ready}, 64'b01);

        // Flush mid-run.
        launch(32'hFFFF, 32'hFFFF);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {61'd0, start_ready, res_valid, busy}, 64'b100);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        launch(32'd7, 32'd6);
        wait_result("after_flush", 64'h2A);

        // Asynchronous reset mid-run, then accept on first edge after release.
        launch(32'd2, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {start_ready, res_valid, busy, product[60:0]}, {1'b1, 63'd0});
        @(negedge clk);
        rst_n = 1'b1;
        start_valid = 1'b1;
        a = 32'd2;
        b = 32'd2;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("accept_after_reset", {63'd0, busy}, 64'd1);
        wait_result("post_reset", 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
